// File: rtl/lsu_bus_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_bus_ctrl
//   Registered load/store unit between the core and a peripheral bus.
//   A single access is accepted at a time. The region-select field of the
//   address picks one of NSLV slaves, the access is run over a req/gnt/ack
//   handshake, store data is lane-replicated and load data is aligned and
//   sign/zero-extended before it is returned to the core.
//
//   Optional feature: define LSU_TIMEOUT_EN to add a watchdog that aborts an
//   access stuck in REQ/ACC for TIMEOUT cycles and reports it as an error.
//
// Ports
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   core_req_i            access request, taken when core_ready_o=1
//   core_we_i             1 = store, 0 = load
//   core_hb_i             size: 00 byte, 01 half, 10 word, 11 reserved
//   core_sext_i           loads: 1 sign-extend, 0 zero-extend
//   core_addr_i           byte address
//   core_wdata_i          right-justified store data
//   core_ready_o          idle, can accept
//   core_valid_o          one-cycle completion pulse
//   core_rdata_o          aligned/extended load data, held until next load
//   core_err_o            fault flag, valid with core_valid_o
//   bus_req_o/bus_gnt_i   bus request / grant
//   bus_ack_i             selected slave completed the access
//   bus_cs_o              one-hot chip select (only during the access phase)
//   bus_addr_o            slave offset address
//   bus_wdata_o           lane-replicated store data
//   bus_we_o, bus_hb_o    write enable and size towards the slave
//   bus_rdata_i           slave read data, slave k at [32k+31:32k]
// -----------------------------------------------------------------------------
module lsu_bus_ctrl #(
    parameter int NSLV    = 4,
    parameter int SEL_MSB = 31,
    parameter int SEL_LSB = 28,
    parameter int OFFS_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               core_req_i,
    input  logic               core_we_i,
    input  logic [1:0]         core_hb_i,
    input  logic               core_sext_i,
    input  logic [31:0]        core_addr_i,
    input  logic [31:0]        core_wdata_i,
    output logic               core_ready_o,
    output logic               core_valid_o,
    output logic [31:0]        core_rdata_o,
    output logic               core_err_o,
    output logic               bus_req_o,
    input  logic               bus_gnt_i,
    input  logic               bus_ack_i,
    output logic [NSLV-1:0]    bus_cs_o,
    output logic [31:0]        bus_addr_o,
    output logic [31:0]        bus_wdata_o,
    output logic               bus_we_o,
    output logic [1:0]         bus_hb_o,
    input  logic [NSLV*32-1:0] bus_rdata_i
);

    localparam int          SW     = SEL_MSB - SEL_LSB + 1;
    localparam logic [31:0] NSLV_U = NSLV;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACC,
        S_RESP,
        S_ERR
    } state_t;

    state_t state_q, state_d;

    // Captured request (data path, no reset needed)
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [1:0]    hb_q, hb_d;
    logic          sext_q, sext_d;
    logic [SW-1:0] idx_q, idx_d;

    // Registered outputs
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            breq_q, breq_d;
    logic [NSLV-1:0] cs_q, cs_d;
    logic [31:0]     baddr_q, baddr_d;
    logic [31:0]     bwdata_q, bwdata_d;
    logic            bwe_q, bwe_d;
    logic [1:0]      bhb_q, bhb_d;

    logic [SW-1:0]   req_idx;
    logic            req_fault;
    logic [31:0]     sel_word;
    logic [NSLV-1:0] cs_onehot;
    logic            expired;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Replicate the low lanes so any byte/half position on the bus sees the data.
    function automatic logic [31:0] replicate_lanes(input logic [1:0] hb, input logic [31:0] d);
        case (hb)
            2'b00:   replicate_lanes = {4{d[7:0]}};
            2'b01:   replicate_lanes = {2{d[15:0]}};
            default: replicate_lanes = d;
        endcase
    endfunction

    // Move the addressed byte/half down to bit 0, then extend.
    function automatic logic [31:0] align_load(input logic [31:0] w, input logic [1:0] offs,
                                               input logic [1:0] hb, input logic sext);
        logic [31:0] sh;
        sh = w >> {offs, 3'b000};
        case (hb)
            2'b00:   align_load = {{24{sext & sh[7]}}, sh[7:0]};
            2'b01:   align_load = {{16{sext & sh[15]}}, sh[15:0]};
            default: align_load = sh;
        endcase
    endfunction

    assign req_idx   = core_addr_i[SEL_MSB:SEL_LSB];
    assign req_fault = (core_hb_i == 2'b11)
                     | ((core_hb_i == 2'b01) & core_addr_i[0])
                     | ((core_hb_i == 2'b10) & (core_addr_i[1:0] != 2'b00))
                     | (32'(req_idx) >= NSLV_U);

    // Read-data mux and chip-select decode for the captured slave index.
    always_comb begin
        sel_word  = '0;
        cs_onehot = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (idx_q == SW'(k)) begin
                sel_word     = bus_rdata_i[k*32 +: 32];
                cs_onehot[k] = 1'b1;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        hb_d     = hb_q;
        sext_d   = sext_q;
        idx_d    = idx_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        breq_d   = breq_q;
        cs_d     = cs_q;
        baddr_d  = baddr_q;
        bwdata_d = bwdata_q;
        bwe_d    = bwe_q;
        bhb_d    = bhb_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (core_req_i) begin
                    addr_d  = core_addr_i;
                    wdata_d = replicate_lanes(core_hb_i, core_wdata_i);
                    we_d    = core_we_i;
                    hb_d    = core_hb_i;
                    sext_d  = core_sext_i;
                    idx_d   = req_idx;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (req_fault) begin
                        // Faulting access never reaches the bus.
                        state_d = S_ERR;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        breq_d  = 1'b1;
                    end
                end
            end

            S_REQ: begin
`ifdef LSU_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (bus_gnt_i) begin
                    state_d  = S_ACC;
                    cs_d     = cs_onehot;
                    baddr_d  = 32'(addr_q[OFFS_W-1:0]);
                    bwdata_d = wdata_q;
                    bwe_d    = we_q;
                    bhb_d    = hb_q;
                end else if (expired) begin
                    state_d = S_RESP;
                    breq_d  = 1'b0;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end
            end

            S_ACC: begin
`ifdef LSU_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                // Ack is tested first so it wins over a same-cycle expiry.
                if (bus_ack_i || expired) begin
                    state_d  = S_RESP;
                    breq_d   = 1'b0;
                    cs_d     = '0;
                    baddr_d  = '0;
                    bwdata_d = '0;
                    bwe_d    = 1'b0;
                    bhb_d    = 2'b00;
                    valid_d  = 1'b1;
                    if (bus_ack_i) begin
                        if (!we_q) begin
                            rdata_d = align_load(sel_word, addr_q[1:0], hb_q, sext_q);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_RESP, S_ERR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            breq_q   <= 1'b0;
            cs_q     <= '0;
            baddr_q  <= '0;
            bwdata_q <= '0;
            bwe_q    <= 1'b0;
            bhb_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            breq_q   <= breq_d;
            cs_q     <= cs_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
            bwe_q    <= bwe_d;
            bhb_q    <= bhb_d;
        end
    end

    always_ff @(posedge clk_i) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        we_q    <= we_d;
        hb_q    <= hb_d;
        sext_q  <= sext_d;
        idx_q   <= idx_d;
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign core_ready_o = ready_q;
    assign core_valid_o = valid_q;
    assign core_err_o   = err_q;
    assign core_rdata_o = rdata_q;
    assign bus_req_o    = breq_q;
    assign bus_cs_o     = cs_q;
    assign bus_addr_o   = baddr_q;
    assign bus_wdata_o  = bwdata_q;
    assign bus_we_o     = bwe_q;
    assign bus_hb_o     = bhb_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_bus_ctrl
//   Self-checking bench for lsu_bus_ctrl. Each access pushes its expected
//   {err, rdata} onto a scoreboard queue when it is driven; the entry is
//   popped and compared when the DUT raises core_valid_o. The bench plays the
//   bus side (grant, ack, slave read data). Timeout cases build only with
//   LSU_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_lsu_bus_ctrl;

    localparam int NSLV    = 4;
    localparam int TIMEOUT = 16;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               core_req_i;
    logic               core_we_i;
    logic [1:0]         core_hb_i;
    logic               core_sext_i;
    logic [31:0]        core_addr_i;
    logic [31:0]        core_wdata_i;
    logic               core_ready_o;
    logic               core_valid_o;
    logic [31:0]        core_rdata_o;
    logic               core_err_o;
    logic               bus_req_o;
    logic               bus_gnt_i;
    logic               bus_ack_i;
    logic [NSLV-1:0]    bus_cs_o;
    logic [31:0]        bus_addr_o;
    logic [31:0]        bus_wdata_o;
    logic               bus_we_o;
    logic [1:0]         bus_hb_o;
    logic [NSLV*32-1:0] bus_rdata_i;

    int errors = 0;
    int checks = 0;

    logic [32:0] sb_q[$];
    logic [31:0] rdata_model = 32'h0;

    always #5 clk_i = ~clk_i;

    lsu_bus_ctrl #(
        .NSLV(NSLV), .SEL_MSB(31), .SEL_LSB(28), .OFFS_W(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_hb_i(core_hb_i),
        .core_sext_i(core_sext_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_ready_o(core_ready_o), .core_valid_o(core_valid_o),
        .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
        .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_ack_i(bus_ack_i),
        .bus_cs_o(bus_cs_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_we_o(bus_we_o), .bus_hb_o(bus_hb_o), .bus_rdata_i(bus_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic is_fault(input logic [1:0] hb, input logic [31:0] a);
        int idx;
        idx = int'(a[31:28]);
        return (hb == 2'b11) || (hb == 2'b01 && a[0]) ||
               (hb == 2'b10 && a[1:0] != 2'b00) || (idx >= NSLV);
    endfunction

    function automatic logic [31:0] exp_lanes(input logic [1:0] hb, input logic [31:0] d);
        logic [31:0] r;
        if (hb == 2'b00)      r = {d[7:0], d[7:0], d[7:0], d[7:0]};
        else if (hb == 2'b01) r = {d[15:0], d[15:0]};
        else                  r = d;
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] hb, input logic sext);
        logic [31:0] sh;
        logic [31:0] r;
        sh = w >> (8 * int'(a[1:0]));
        if (hb == 2'b00)      r = (sext && sh[7])  ? (32'hFFFFFF00 | {24'h0, sh[7:0]})  : {24'h0, sh[7:0]};
        else if (hb == 2'b01) r = (sext && sh[15]) ? (32'hFFFF0000 | {16'h0, sh[15:0]}) : {16'h0, sh[15:0]};
        else                  r = sh;
        return r;
    endfunction

    task automatic check_completion(input string tag);
        logic [32:0] e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_valid"}, 32'(core_valid_o), 32'd1);
            check({tag, "_err"},   32'(core_err_o),   32'(e[32]));
            check({tag, "_rdata"}, core_rdata_o,      e[31:0]);
            check({tag, "_busy"},  32'(core_ready_o), 32'd0);
        end
        @(negedge clk_i);
        check({tag, "_pulse"}, 32'(core_valid_o), 32'd0);
        check({tag, "_ready"}, 32'(core_ready_o), 32'd1);
    endtask

    // One complete access; the bench answers as the bus with gnt after
    // gnt_wait extra cycles and ack in the first access-phase cycle.
    task automatic access(input string tag, input logic we, input logic [1:0] hb,
                          input logic sext, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] word,
                          input int gnt_wait);
        logic fault;
        int   idx;
        idx   = int'(addr[31:28]);
        fault = is_fault(hb, addr);
        @(negedge clk_i);
        core_req_i   = 1'b1;
        core_we_i    = we;
        core_hb_i    = hb;
        core_sext_i  = sext;
        core_addr_i  = addr;
        core_wdata_i = wdata;
        if (!fault && !we) rdata_model = exp_load(word, addr, hb, sext);
        sb_q.push_back({fault, rdata_model});
        @(posedge clk_i);
        #1 core_req_i = 1'b0;
        @(negedge clk_i);
        if (fault) begin
            check({tag, "_no_req"}, 32'(bus_req_o), 32'd0);
            check({tag, "_no_cs"},  32'(bus_cs_o),  32'd0);
        end else begin
            check({tag, "_req"},    32'(bus_req_o), 32'd1);
            check({tag, "_cs_req"}, 32'(bus_cs_o),  32'd0);
            repeat (gnt_wait) @(negedge clk_i);
            check({tag, "_req_hold"}, 32'(bus_req_o), 32'd1);
            bus_gnt_i = 1'b1;
            @(negedge clk_i);
            bus_gnt_i = 1'b0;
            check({tag, "_cs"},    32'(bus_cs_o), 32'(1 << idx));
            check({tag, "_addr"},  bus_addr_o,    {24'h0, addr[7:0]});
            check({tag, "_we"},    32'(bus_we_o), 32'(we));
            check({tag, "_hb"},    32'(bus_hb_o), 32'(hb));
            if (we) check({tag, "_wdata"}, bus_wdata_o, exp_lanes(hb, wdata));
            bus_rdata_i = '0;
            bus_rdata_i[idx*32 +: 32] = word;
            bus_ack_i = 1'b1;
            @(negedge clk_i);
            bus_ack_i = 1'b0;
            check({tag, "_cs_drop"},  32'(bus_cs_o),  32'd0);
            check({tag, "_req_drop"}, 32'(bus_req_o), 32'd0);
        end
        check_completion(tag);
    endtask

`ifdef LSU_TIMEOUT_EN
    // Grant, then either never ack or ack exactly in the expiry cycle.
    task automatic timeout_run(input string tag, input logic ack_late);
        int n;
        n = 0;
        @(negedge clk_i);
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_hb_i   = 2'b10;
        core_sext_i = 1'b0;
        core_addr_i = 32'h1000_0000;
        if (ack_late) rdata_model = 32'hCAFE_F00D;
        sb_q.push_back({~ack_late, rdata_model});
        @(posedge clk_i);
        #1 core_req_i = 1'b0;
        while (n < 40) begin
            @(negedge clk_i);
            n++;
            bus_ack_i = 1'b0;
            if (core_valid_o) break;
            bus_gnt_i = (n == 1);
            if (ack_late && n == TIMEOUT) begin
                bus_rdata_i = '0;
                bus_rdata_i[63:32] = 32'hCAFE_F00D;
                bus_ack_i = 1'b1;
            end
        end
        bus_gnt_i = 1'b0;
        check({tag, "_latency"}, 32'(n),        32'(TIMEOUT + 1));
        check({tag, "_cs"},      32'(bus_cs_o), 32'd0);
        check({tag, "_req"},     32'(bus_req_o), 32'd0);
        check_completion(tag);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        rst_i        = 1'b1;
        core_req_i   = 1'b0;
        core_we_i    = 1'b0;
        core_hb_i    = 2'b00;
        core_sext_i  = 1'b0;
        core_addr_i  = '0;
        core_wdata_i = '0;
        bus_gnt_i    = 1'b0;
        bus_ack_i    = 1'b0;
        bus_rdata_i  = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_ready", 32'(core_ready_o), 32'd1);
        check("rst_valid", 32'(core_valid_o), 32'd0);
        check("rst_err",   32'(core_err_o),   32'd0);
        check("rst_rdata", core_rdata_o,      32'd0);
        check("rst_req",   32'(bus_req_o),    32'd0);
        check("rst_cs",    32'(bus_cs_o),     32'd0);

        access("wload",   1'b0, 2'b10, 1'b0, 32'h1000_0004, 32'h0,         32'hDEAD_BEEF, 0);
        access("bload_s", 1'b0, 2'b00, 1'b1, 32'h1000_0003, 32'h0,         32'h80AB_CDEF, 0);
        check("bload_s_val", core_rdata_o, 32'hFFFF_FF80);
        access("bload_z", 1'b0, 2'b00, 1'b0, 32'h1000_0003, 32'h0,         32'h80AB_CDEF, 0);
        check("bload_z_val", core_rdata_o, 32'h0000_0080);
        access("hstore",  1'b1, 2'b01, 1'b0, 32'h2000_0002, 32'h0000_1234, 32'h5555_5555, 0);
        access("f_align", 1'b0, 2'b10, 1'b0, 32'h1000_0002, 32'h0,         32'h0,         0);
        access("f_hb",    1'b0, 2'b11, 1'b0, 32'h1000_0000, 32'h0,         32'h0,         0);
        access("f_idx",   1'b0, 2'b10, 1'b0, 32'h5000_0000, 32'h0,         32'h0,         0);
        access("hload_s", 1'b0, 2'b01, 1'b1, 32'h3000_0002, 32'h0,         32'h8001_7FFF, 3);
        access("bstore",  1'b1, 2'b00, 1'b0, 32'h0000_0041, 32'h0000_00A5, 32'h0,         1);

        // Reset while the access phase is active.
        @(negedge clk_i);
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_hb_i   = 2'b10;
        core_addr_i = 32'h2000_0010;
        @(posedge clk_i);
        #1 core_req_i = 1'b0;
        @(negedge clk_i);
        bus_gnt_i = 1'b1;
        @(negedge clk_i);
        bus_gnt_i = 1'b0;
        check("rst_acc_cs", 32'(bus_cs_o), 32'h4);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        rdata_model = 32'h0;
        check("rst_acc_ready", 32'(core_ready_o), 32'd1);
        check("rst_acc_cs0",   32'(bus_cs_o),     32'd0);
        check("rst_acc_req",   32'(bus_req_o),    32'd0);
        check("rst_acc_valid", 32'(core_valid_o), 32'd0);
        @(negedge clk_i);
        check("rst_acc_novalid", 32'(core_valid_o), 32'd0);
        access("post_rst", 1'b0, 2'b10, 1'b0, 32'h2000_0008, 32'h0, 32'h1234_5678, 0);

`ifdef LSU_TIMEOUT_EN
        timeout_run("tmo", 1'b0);
        timeout_run("tmo_ack", 1'b1);
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
